// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: M-bit A times N-bit B over N cycles,
// unsigned or two's-complement, with valid/ready handshakes on both sides.
`timescale 1ns/1ps

module seq_multiplier #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+N-1:0]   P,
    output logic             busy
);

    localparam int W  = M + N;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q,  state_d;
    logic [W-1:0]    mcand_q,  mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [W-1:0]    acc_q,    acc_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            neg_q,    neg_d;
    logic [W-1:0]    p_q,      p_d;

    logic            a_neg;
    logic            b_neg;
    logic [M-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic [W-1:0]    addend;
    logic [W-1:0]    sum;

    // Magnitudes of the most negative values wrap to 2^(M-1) / 2^(N-1),
    // which are exactly right when read back as unsigned.
    always_comb begin
        a_neg  = signed_mode & A[M-1];
        b_neg  = signed_mode & B[N-1];
        a_mag  = a_neg ? (~A + M'(1)) : A;
        b_mag  = b_neg ? (~B + N'(1)) : B;
        addend = mplier_q[0] ? mcand_q : '0;
        sum    = acc_q + addend;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        p_d      = p_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = W'(a_mag);
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = a_neg ^ b_neg;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // The final addition is folded straight into P so the result
                // is visible on the same edge that enters DONE.
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    p_d     = neg_q ? (~sum + W'(1)) : sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign P         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: a 4x3 instance for directed cases
// and an 8x8 instance checked every cycle against an arithmetic scoreboard.
`timescale 1ns/1ps

module tb_seq_multiplier;

    logic clk;
    int   checks;
    int   errors;

    // 4x3 instance
    logic       s_rst, s_in_valid, s_in_ready, s_mode, s_out_valid, s_out_ready, s_busy;
    logic [3:0] s_A;
    logic [2:0] s_B;
    logic [6:0] s_P;

    // 8x8 instance
    logic        b_rst, b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_busy;
    logic [7:0]  b_A, b_B;
    logic [15:0] b_P;
    logic        rdy_rand, rnd_rdy, man_rdy;

    longint exp_q[$];
    longint prev_p;
    bit     prev_hold;
    int     cyc, hs_cyc, sent, done;

    seq_multiplier #(.M(4), .N(3)) u_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .A(s_A), .B(s_B), .signed_mode(s_mode), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .P(s_P), .busy(s_busy)
    );

    seq_multiplier #(.M(8), .N(8)) u_big (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .A(b_A), .B(b_B), .signed_mode(b_mode), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .P(b_P), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign b_out_ready = rdy_rand ? rnd_rdy : man_rdy;

    always @(posedge clk) #1 rnd_rdy = ($urandom_range(0, 3) != 0);

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Product of A and B, each read as signed when mode=1, truncated to m+n bits.
    function automatic longint ref_prod(input int m, input int n, input longint a,
                                        input longint b, input bit mode);
        longint av, bv, mask;
        av = a;
        bv = b;
        if (mode && a[m-1]) av = a - (longint'(1) << m);
        if (mode && b[n-1]) bv = b - (longint'(1) << n);
        mask = (longint'(1) << (m + n)) - 1;
        return (av * bv) & mask;
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Scoreboard for the 8x8 instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (b_rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(ref_prod(8, 8, b_A, b_B, b_mode));
                hs_cyc = cyc + 1;
                sent++;
            end
            if (b_out_valid) begin
                if (!prev_hold) chk("big latency", cyc - hs_cyc, 8);
                else            chk("big P stable", b_P, prev_p);
                chk("big in_ready in DONE", b_in_ready, 0);
                chk("big busy in DONE", b_busy, 1);
                if (b_out_ready) begin
                    chk("big result expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("big P", b_P, exp_q.pop_front());
                    done++;
                end
            end
            prev_hold = b_out_valid && !b_out_ready;
            prev_p    = b_P;
        end
    end

    task automatic run_small(input logic [3:0] a, input logic [2:0] b, input bit mode,
                             input longint expv, input string nm);
        int  n;
        bit  seen;
        chk({nm, " model"}, ref_prod(4, 3, a, b, mode), expv);
        chk({nm, " in_ready idle"}, s_in_ready, 1);
        s_A = a; s_B = b; s_mode = mode; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_A = ~a; s_B = ~b; s_mode = ~mode;
        seen = 1'b0;
        for (n = 0; n < 20; n++) begin
            if (s_out_valid) begin
                seen = 1'b1;
                break;
            end
            chk({nm, " in_ready CALC"}, s_in_ready, 0);
            chk({nm, " busy CALC"}, s_busy, 1);
            @(posedge clk); #1;
        end
        chk({nm, " latency"}, seen ? n : -1, 3);
        chk({nm, " P"}, s_P, expv);
        chk({nm, " in_ready DONE"}, s_in_ready, 0);
        @(posedge clk); #1;
        chk({nm, " out_valid held"}, s_out_valid, 1);
        chk({nm, " P held"}, s_P, expv);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        chk({nm, " out_valid drop"}, s_out_valid, 0);
        chk({nm, " in_ready after"}, s_in_ready, 1);
        chk({nm, " busy after"}, s_busy, 0);
        chk({nm, " P kept"}, s_P, expv);
    endtask

    task automatic send_big(input logic [7:0] a, input logic [7:0] b, input bit mode);
        bit ok;
        ok = 1'b0;
        b_A = a; b_B = b; b_mode = mode; b_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (b_in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        b_A = ~a; b_B = ~b; b_mode = ~mode;
        chk("big accept", b_in_ready | ok, 1);
    endtask

    task automatic wait_big();
        for (int i = 0; i < 40; i++) begin
            if (b_out_valid) return;
            @(posedge clk); #1;
        end
        chk("big out_valid timeout", b_out_valid, 1);
    endtask

    task automatic accept_big();
        man_rdy = 1'b1;
        @(posedge clk); #1;
        man_rdy = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; sent = 0; done = 0; hs_cyc = 0;
        s_rst = 1'b1; b_rst = 1'b1;
        s_in_valid = 1'b0; s_A = '0; s_B = '0; s_mode = 1'b0; s_out_ready = 1'b0;
        b_in_valid = 1'b0; b_A = '0; b_B = '0; b_mode = 1'b0;
        rdy_rand = 1'b0; man_rdy = 1'b0;
        prev_hold = 1'b0; prev_p = 0;
        #1;
        chk("reset small P", s_P, 0);
        chk("reset small out_valid", s_out_valid, 0);
        chk("reset small busy", s_busy, 0);
        chk("reset small in_ready", s_in_ready, 0);
        chk("reset big P", b_P, 0);
        chk("reset big in_ready", b_in_ready, 0);
        chk("model 8x8 min*min", ref_prod(8, 8, 8'h80, 8'h80, 1), 16'h4000);
        chk("model 8x8 ff*ff", ref_prod(8, 8, 255, 255, 0), 16'hFE01);
        @(posedge clk); @(posedge clk); #1;
        s_rst = 1'b0; b_rst = 1'b0;
        #1;
        chk("small in_ready after reset", s_in_ready, 1);
        chk("big in_ready after reset", b_in_ready, 1);

        run_small(4'd15, 3'd7, 1'b0, 7'h69, "u15x7");
        run_small(4'h8, 3'd3, 1'b1, 7'h68, "s-8x3");
        run_small(4'h8, 3'h4, 1'b1, 7'h20, "s-8x-4");
        run_small(4'h0, 3'h4, 1'b1, 7'h00, "s0x-4");
        run_small(4'h7, 3'h7, 1'b1, 7'h79, "s7x-1");

        // Backpressure with an ignored in_valid pulse while DONE.
        send_big(8'd255, 8'd255, 1'b0);
        wait_big();
        chk("bp P", b_P, 16'hFE01);
        for (int k = 0; k < 5; k++) begin
            b_in_valid = (k == 2);
            b_A = 8'd1; b_B = 8'd1; b_mode = 1'b0;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            chk("bp out_valid", b_out_valid, 1);
            chk("bp P", b_P, 16'hFE01);
            chk("bp in_ready", b_in_ready, 0);
        end
        accept_big();
        chk("bp out_valid drop", b_out_valid, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp pulse ignored", b_busy, 0);
        end

        // Reset two cycles into CALC.
        send_big(8'd200, 8'd100, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        b_rst = 1'b1;
        #1;
        chk("rst P", b_P, 0);
        chk("rst out_valid", b_out_valid, 0);
        chk("rst busy", b_busy, 0);
        chk("rst in_ready", b_in_ready, 0);
        @(posedge clk); #1;
        b_rst = 1'b0;
        #1;
        chk("rst release in_ready", b_in_ready, 1);
        send_big(8'd3, 8'd2, 1'b0);
        wait_big();
        chk("post-rst P", b_P, 6);
        accept_big();

        // Signed corners through the scoreboard.
        send_big(8'h80, 8'h80, 1'b1); wait_big(); chk("big min*min", b_P, 16'h4000); accept_big();
        send_big(8'h00, 8'hFF, 1'b1); wait_big(); chk("big 0*-1", b_P, 16'h0000); accept_big();
        send_big(8'h7F, 8'h80, 1'b1); wait_big(); chk("big 127*-128", b_P, 16'hC080); accept_big();

        // Random sweep with input gaps and random output backpressure.
        sent = 0; done = 0;
        rdy_rand = 1'b1;
        for (int j = 0; j < 1000; j++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_big(8'($urandom), 8'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !b_busy) break;
            @(posedge clk); #1;
        end
        rdy_rand = 1'b0;
        chk("sweep drained", exp_q.size(), 0);
        chk("sweep none lost", done, sent);
        chk("sweep count", sent, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parameterized sequential shift-add multiplier. It is the clocked successor to the team's combinational unsigned array multiplier and adds a signed/unsigned mode select and valid/ready handshakes on both sides. It takes an M-bit operand A and an N-bit operand B and returns the (M+N)-bit product after N compute cycles. It uses one adder, so it suits area-constrained datapaths that can tolerate multi-cycle latency.

Parameters:
M, 8, width of multiplicand A (M >= 2)
N, 8, width of multiplier B (N >= 2); also the number of compute cycles

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  A, B and signed_mode are valid
in_ready  output  1  block can accept an operand pair
A  input  M  multiplicand
B  input  N  multiplier
signed_mode  input  1  0 = unsigned operands; 1 = two's-complement operands; sampled with A/B
out_valid  output  1  P holds a completed product
out_ready  input  1  consumer accepts P
P  output  M+N  product: unsigned, or two's complement when the accepted signed_mode = 1
busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, asynchronous and active-high.
- While rst = 1:
  - state = IDLE.
  - P, out_valid and busy = 0.
  - in_ready = 0.
  - All internal registers are cleared.
- After rst deasserts: in_ready = 1 from the first cycle.
- States: IDLE, CALC, DONE.
- in_ready = (state == IDLE) and not rst. It is combinational from the state.
- IDLE:
  - On a rising edge with in_valid and in_ready both high, capture A, B and signed_mode.
  - When signed_mode = 1, convert each operand to its magnitude and register neg = sign(A) XOR sign(B).
  - The magnitude of the most negative value is 2^(M-1) or 2^(N-1). This fits unsigned in M or N bits.
  - Clear the accumulator and the cycle counter, then go to CALC.
- CALC, N cycles, one multiplier bit per cycle, LSB first:
  - If the current bit is 1, add the multiplicand magnitude, shifted by the bit index, to the (M+N)-bit accumulator.
  - Every intermediate sum fits in M+N bits, so nothing is truncated.
  - When the counter reaches N-1, the last addition is done and the state goes to DONE on the next edge.
  - On that edge, load P with the accumulator, two's-complement negated if neg = 1.
- Latency: out_valid rises exactly N cycles after the input handshake edge. The timing does not depend on operand values, and there is no early exit on zero.
- DONE:
  - out_valid = 1. P holds stable until the output handshake.
  - On an edge with out_valid and out_ready both high, go to IDLE and drop out_valid. P keeps its last value.
  - in_ready is 1 in the following cycle.
  - Back-to-back throughput is one result per N+2 cycles.
- in_valid while busy is ignored; the block never drops or overwrites an accepted job.
- The upstream side must hold A, B and signed_mode only during the handshake cycle; the block does not sample them afterwards.
- Signed result rules:
  - Zero times a negative operand gives 0; there is no negative zero.
  - (-2^(M-1)) * (-2^(N-1)) = 2^(M+N-2). This is representable and must be produced exactly.
- Reset mid-operation: any state aborts immediately. out_valid drops and P = 0 asynchronously. The in-flight job is lost, and the block is in IDLE after release.
- out_ready high while out_valid = 0 has no effect.

Test Plan:
- M=4, N=3, unsigned, A=15, B=7 -> out_valid exactly 3 cycles after the handshake edge, P = 105 (0x69); in_ready low during CALC and DONE.
- M=4, N=3, signed, A=-8 (0x8), B=3 -> P = -24 = 0x68 (7-bit two's complement).
- M=4, N=3, signed, A=-8, B=-4 -> P = 32 = 0x20; A=0, B=-4 -> P = 0.
- Backpressure: M=8, N=8, unsigned, A=255, B=255 -> P = 65025 (0xFE01); hold out_ready low 5 cycles -> out_valid and P stable throughout, in_ready stays 0, and a second in_valid pulse in that window is ignored.
- Reset mid-op: assert rst asynchronously 2 cycles into CALC -> P, out_valid and busy go to 0 before the next edge; after release, in_ready = 1; the next job, A=3, B=2 unsigned, gives P = 6.
- Random sweep: 1000 random operands in mixed modes with random in_valid/out_ready gaps -> every P matches a reference model of A*B sign-extended per mode to M+N bits, in order, with none lost.
